wb_arbiter_2m: RTL and testbench

Two-master Wishbone classic arbiter sharing the single SoC slave bus between the picorv32_wb CPU (master 0) and a DMA/peripheral master (master 1). Round-robin grant with direct hand-off, ack/err routed only to the granted master. Optional bus-timeout watchdog terminates cycles no slave acknowledges. Sits between the CPU wrapper and the slave address decoder.

---
 rtl/wb_arb_pkg.sv | 15 +
 rtl/wb_arbiter_2m_timeout.sv | 34 +++
 rtl/wb_arbiter_2m.sv | 151 +++++++++++++++
 tb/tb_wb_arbiter_2m.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_e;

   localparam int M_CPU = 0;
   localparam int M_DMA = 1;

   localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/wb_arbiter_2m_timeout.sv
// Bus watchdog: counts stalled strobe cycles and forces a one-cycle error.
// Used by wb_arbiter_2m only when WB_ARB_TIMEOUT_EN is defined.
module wb_arb_timeout
   import wb_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic stb,
   input  logic ack,
   input  logic clear,
   output logic err
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;

   // a same-cycle ack takes priority over the forced error
   assign err = stb & ~ack & (cnt_q == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear | ack | err) begin
         cnt_q <= '0;
      end else if (stb) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone classic round-robin arbiter with direct hand-off.
// Define WB_ARB_TIMEOUT_EN to enable the bus-timeout watchdog.
module wb_arbiter_2m
   import wb_arb_pkg::*;
#(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_ni,
   input  logic [AW-1:0] m0_adr_i,
   input  logic [DW-1:0] m0_dat_i,
   output logic [DW-1:0] m0_dat_o,
   input  logic          m0_we_i,
   input  logic          m0_stb_i,
   input  logic          m0_cyc_i,
   input  logic [DW/8-1:0] m0_sel_i,
   output logic          m0_ack_o,
   output logic          m0_err_o,
   input  logic [AW-1:0] m1_adr_i,
   input  logic [DW-1:0] m1_dat_i,
   output logic [DW-1:0] m1_dat_o,
   input  logic          m1_we_i,
   input  logic          m1_stb_i,
   input  logic          m1_cyc_i,
   input  logic [DW/8-1:0] m1_sel_i,
   output logic          m1_ack_o,
   output logic          m1_err_o,
   output logic [AW-1:0] s_adr_o,
   output logic [DW-1:0] s_dat_o,
   output logic [DW/8-1:0] s_sel_o,
   output logic          s_we_o,
   output logic          s_stb_o,
   output logic          s_cyc_o,
   input  logic [DW-1:0] s_dat_i,
   input  logic          s_ack_i,
   output logic [1:0]    grant_o
);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_tmo
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   arb_state_e state_q, state_d;
   logic       last_q;
   logic       ack;
   logic       tmo_err;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         if (state_d == GNT0) begin
            last_q <= 1'b0;
         end else if (state_d == GNT1) begin
            last_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               state_d = last_q ? GNT0 : GNT1;
            end else if (m0_cyc_i) begin
               state_d = GNT0;
            end else if (m1_cyc_i) begin
               state_d = GNT1;
            end
         end
         GNT0: begin
            if (!m0_cyc_i) begin
               state_d = m1_cyc_i ? GNT1 : IDLE;
            end
         end
         GNT1: begin
            if (!m1_cyc_i) begin
               state_d = m0_cyc_i ? GNT0 : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_o = '0;
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      s_we_o  = 1'b0;
      s_stb_o = 1'b0;
      s_cyc_o = 1'b0;
      case (state_q)
         GNT0: begin
            grant_o[M_CPU] = 1'b1;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_we_o  = m0_we_i;
            s_stb_o = m0_stb_i;
            s_cyc_o = m0_cyc_i;
         end
         GNT1: begin
            grant_o[M_DMA] = 1'b1;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_we_o  = m1_we_i;
            s_stb_o = m1_stb_i;
            s_cyc_o = m1_cyc_i;
         end
         default: ;
      endcase
   end

   // stray acks outside an active strobe never reach a master
   assign ack = s_ack_i & s_stb_o;

   assign m0_ack_o = ack & grant_o[M_CPU];
   assign m1_ack_o = ack & grant_o[M_DMA];
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
   logic tmo_clear;

   assign tmo_clear = (state_q == IDLE) | (state_d != state_q);

   wb_arb_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_ni),
      .stb   (s_stb_o),
      .ack   (ack),
      .clear (tmo_clear),
      .err   (tmo_err)
   );
`else
   assign tmo_err = 1'b0;
`endif

   assign m0_err_o = tmo_err & grant_o[M_CPU];
   assign m1_err_o = tmo_err & grant_o[M_DMA];

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed self-checking bench for wb_arbiter_2m.
module tb_wb_arbiter_2m;

   logic        clk;
   logic        rst_n;
   logic [31:0] m0_adr, m0_dat_w, m0_dat_r;
   logic        m0_we, m0_stb, m0_cyc, m0_ack, m0_err;
   logic [3:0]  m0_sel;
   logic [31:0] m1_adr, m1_dat_w, m1_dat_r;
   logic        m1_we, m1_stb, m1_cyc, m1_ack, m1_err;
   logic [3:0]  m1_sel;
   logic [31:0] s_adr, s_dat_w, s_dat_r;
   logic [3:0]  s_sel;
   logic        s_we, s_stb, s_cyc, s_ack;
   logic [1:0]  grant;

   int checks = 0;
   int errors = 0;

   wb_arbiter_2m #(
      .AW(32), .DW(32), .TIMEOUT_CYCLES(8)
   ) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .m0_adr_i(m0_adr), .m0_dat_i(m0_dat_w), .m0_dat_o(m0_dat_r),
      .m0_we_i(m0_we), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc),
      .m0_sel_i(m0_sel), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
      .m1_adr_i(m1_adr), .m1_dat_i(m1_dat_w), .m1_dat_o(m1_dat_r),
      .m1_we_i(m1_we), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc),
      .m1_sel_i(m1_sel), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
      .s_adr_o(s_adr), .s_dat_o(s_dat_w), .s_sel_o(s_sel),
      .s_we_o(s_we), .s_stb_o(s_stb), .s_cyc_o(s_cyc),
      .s_dat_i(s_dat_r), .s_ack_i(s_ack), .grant_o(grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_adr = '0; m0_dat_w = '0; m0_we = 0; m0_stb = 0; m0_cyc = 0; m0_sel = '0;
      m1_adr = '0; m1_dat_w = '0; m1_we = 0; m1_stb = 0; m1_cyc = 0; m1_sel = '0;
      s_dat_r = '0; s_ack = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;
      tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      s_ack = 1;
      #2;
      checks++;
      if (grant !== 2'b00) begin
         errors++; $display("FAIL reset_grant got %b exp 00", grant);
      end
      checks++;
      if ({s_cyc, s_stb, s_we, m0_ack, m1_ack, m0_err, m1_err} !== 7'b0) begin
         errors++; $display("FAIL reset_ctl got %b exp 0", {s_cyc, s_stb, s_we, m0_ack, m1_ack, m0_err, m1_err});
      end
      checks++;
      if (s_adr !== 32'h0 || s_sel !== 4'h0) begin
         errors++; $display("FAIL reset_adr got %h/%h exp 0/0", s_adr, s_sel);
      end
      s_ack = 0;
      tick();
      rst_n = 1;
      tick();
   endtask

   task automatic test_read();
      m0_adr = 32'h0000_1000; m0_sel = 4'hF; m0_we = 0;
      m0_cyc = 1; m0_stb = 1;
      #1;
      checks++;
      if (grant !== 2'b00) begin
         errors++; $display("FAIL read_pre_grant got %b exp 00", grant);
      end
      tick();
      checks++;
      if (grant !== 2'b01 || s_cyc !== 1 || s_stb !== 1) begin
         errors++; $display("FAIL read_grant got %b cyc %b stb %b exp 01 1 1", grant, s_cyc, s_stb);
      end
      checks++;
      if (s_adr !== 32'h0000_1000 || s_we !== 0) begin
         errors++; $display("FAIL read_adr got %h we %b exp 00001000 0", s_adr, s_we);
      end
      tick();
      tick();
      checks++;
      if (m0_ack !== 0) begin
         errors++; $display("FAIL read_early_ack got %b exp 0", m0_ack);
      end
      s_ack = 1; s_dat_r = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (m0_ack !== 1 || m0_dat_r !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL read_ack got %b %h exp 1 deadbeef", m0_ack, m0_dat_r);
      end
      checks++;
      if (m1_ack !== 0 || m0_err !== 0 || m1_err !== 0) begin
         errors++; $display("FAIL read_other got %b%b%b exp 000", m1_ack, m0_err, m1_err);
      end
      tick();
      s_ack = 0; m0_cyc = 0; m0_stb = 0;
      tick();
      checks++;
      if (grant !== 2'b00 || s_cyc !== 0) begin
         errors++; $display("FAIL read_release got %b %b exp 00 0", grant, s_cyc);
      end
   endtask

   task automatic test_tie();
      do_reset();
      m0_adr = 32'hA000; m1_adr = 32'hB000;
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      tick();
      checks++;
      if (grant !== 2'b01 || s_adr !== 32'hA000) begin
         errors++; $display("FAIL tie_first got %b %h exp 01 a000", grant, s_adr);
      end
      s_ack = 1;
      #1;
      checks++;
      if (m0_ack !== 1 || m1_ack !== 0) begin
         errors++; $display("FAIL tie_ack_route got %b%b exp 10", m0_ack, m1_ack);
      end
      tick();
      s_ack = 0; m0_cyc = 0; m0_stb = 0;
      tick();
      checks++;
      if (grant !== 2'b10 || s_adr !== 32'hB000 || s_cyc !== 1) begin
         errors++; $display("FAIL tie_handoff got %b %h %b exp 10 b000 1", grant, s_adr, s_cyc);
      end
      m1_cyc = 0; m1_stb = 0;
      tick();
      checks++;
      if (grant !== 2'b00) begin
         errors++; $display("FAIL tie_idle got %b exp 00", grant);
      end
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      tick();
      checks++;
      if (grant !== 2'b01) begin
         errors++; $display("FAIL tie_second got %b exp 01", grant);
      end
      m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
      tick();
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] dat [4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
      logic [3:0]  sel [4] = '{4'h1, 4'h3, 4'hC, 4'hF};
      m1_cyc = 1; m1_stb = 1; m1_we = 1;
      m1_adr = 32'h2000_0000; m1_dat_w = dat[0]; m1_sel = sel[0];
      tick();
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0040;
      for (int k = 0; k < 4; k++) begin
         m1_adr = 32'h2000_0000 + 32'(4 * k);
         m1_dat_w = dat[k]; m1_sel = sel[k];
         s_ack = 1;
         #1;
         checks++;
         if (grant !== 2'b10 || s_dat_w !== dat[k] || s_sel !== sel[k] || s_we !== 1) begin
            errors++; $display("FAIL b2b_%0d got %b %h %h %b exp 10 %h %h 1", k, grant, s_dat_w, s_sel, s_we, dat[k], sel[k]);
         end
         checks++;
         if (m1_ack !== 1 || m0_ack !== 0) begin
            errors++; $display("FAIL b2b_ack_%0d got %b%b exp 10", k, m1_ack, m0_ack);
         end
         tick();
      end
      s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
      tick();
      checks++;
      if (grant !== 2'b01 || s_adr !== 32'h0000_0040) begin
         errors++; $display("FAIL b2b_handoff got %b %h exp 01 00000040", grant, s_adr);
      end
      m0_cyc = 0; m0_stb = 0;
      tick();
   endtask

   task automatic test_reset_mid();
      m1_cyc = 1; m1_stb = 1; m1_adr = 32'h3000;
      tick();
      checks++;
      if (grant !== 2'b10) begin
         errors++; $display("FAIL rmid_grant got %b exp 10", grant);
      end
      m0_cyc = 1; m0_stb = 1;
      #1;
      rst_n = 0;
      s_ack = 1;
      #1;
      checks++;
      if (s_cyc !== 0 || s_stb !== 0 || grant !== 2'b00) begin
         errors++; $display("FAIL rmid_drop got %b%b %b exp 00 00", s_cyc, s_stb, grant);
      end
      checks++;
      if (m1_ack !== 0 || m0_ack !== 0) begin
         errors++; $display("FAIL rmid_ack got %b%b exp 00", m1_ack, m0_ack);
      end
      s_ack = 0;
      tick();
      rst_n = 1;
      tick();
      checks++;
      if (grant !== 2'b01) begin
         errors++; $display("FAIL rmid_after got %b exp 01", grant);
      end
      m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
      tick();
      tick();
   endtask

`ifdef WB_ARB_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      m0_cyc = 1; m0_stb = 1;
      tick();
      for (int k = 0; k < 7; k++) begin
         checks++;
         if (m0_err !== 0) begin
            errors++; $display("FAIL tmo_early_%0d got %b exp 0", k, m0_err);
         end
         tick();
      end
      checks++;
      if (m0_err !== 1 || m1_err !== 0 || m0_ack !== 0) begin
         errors++; $display("FAIL tmo_err got %b%b%b exp 100", m0_err, m1_err, m0_ack);
      end
      tick();
      checks++;
      if (m0_err !== 0) begin
         errors++; $display("FAIL tmo_pulse got %b exp 0", m0_err);
      end
      for (int k = 0; k < 7; k++) tick();
      s_ack = 1;
      #1;
      checks++;
      if (m0_ack !== 1 || m0_err !== 0) begin
         errors++; $display("FAIL tmo_ack_wins got %b%b exp 10", m0_ack, m0_err);
      end
      tick();
      s_ack = 0; m0_cyc = 0; m0_stb = 0;
      tick();
   endtask
`else
   task automatic test_no_timeout();
      int bad;
      bad = 0;
      m0_cyc = 1; m0_stb = 1;
      tick();
      for (int k = 0; k < 1000; k++) begin
         if (m0_err !== 0 || m1_err !== 0 || grant !== 2'b01) bad++;
         tick();
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL no_tmo got %0d bad cycles exp 0", bad);
      end
      checks++;
      if (grant !== 2'b01 || s_stb !== 1) begin
         errors++; $display("FAIL no_tmo_hold got %b %b exp 01 1", grant, s_stb);
      end
      m0_cyc = 0; m0_stb = 0;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_read();
      test_tie();
      test_back_to_back();
      test_reset_mid();
`ifdef WB_ARB_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
